// File: rtl/led_blink_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_blink_pkg
//  Description : Shared types, mode encodings and helpers for the
//                multi-channel LED blink controller.
//                Optional macro LED_BLINK_ACTIVE_LOW_EN selects inverted
//                (active-low) LED pin polarity.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_blink_pkg;

    typedef enum logic [1:0] {
        LED_OFF     = 2'b00,
        LED_ON      = 2'b01,
        LED_BLINK   = 2'b10,
        LED_ONESHOT = 2'b11
    } led_mode_e;

    localparam logic [1:0] c_MODE_OFF     = 2'b00;
    localparam logic [1:0] c_MODE_ON      = 2'b01;
    localparam logic [1:0] c_MODE_BLINK   = 2'b10;
    localparam logic [1:0] c_MODE_ONESHOT = 2'b11;

    // Widest counter supported by the helper below.
    localparam int c_MAX_CNT_W = 64;

    // Pin polarity: XORed into every value loaded into the LED output flop.
`ifdef LED_BLINK_ACTIVE_LOW_EN
    localparam logic c_LED_INV = 1'b1;
`else
    localparam logic c_LED_INV = 1'b0;
`endif

    // Effective half-period: a programmed zero behaves as one cycle.
    function automatic logic [c_MAX_CNT_W-1:0] led_heff(input logic [c_MAX_CNT_W-1:0] half);
        return (half == '0) ? c_MAX_CNT_W'(1) : half;
    endfunction

endpackage : led_blink_pkg
`default_nettype wire

// File: rtl/led_blink_chan.sv
`default_nettype none
// ============================================================================
//  Module      : led_blink_chan
//  Description : One LED channel: mode register, half-period register,
//                cycle counter, registered LED pin and transition tick.
//                Pin polarity follows LED_BLINK_ACTIVE_LOW_EN via the package.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_blink_chan
    import led_blink_pkg::*;
#(
    parameter int               CNT_W    = 24,
    parameter logic [CNT_W-1:0] RST_HALF = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_i,
    input  logic [1:0]       mode_i,
    input  logic [CNT_W-1:0] half_i,
    output logic             led_o,
    output logic             tick_o
);

    led_mode_e        mode_q, mode_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             led_q,  led_d;   // holds the pin level (polarity applied)
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] w_last;
    logic             w_term;

    // Terminal count is heff-1; ">=" keeps the counter from ever running past it.
    assign w_last = CNT_W'(led_heff(c_MAX_CNT_W'(half_q)) - c_MAX_CNT_W'(1));
    assign w_term = (cnt_q >= w_last);

    // State registers; reset restarts the channel in BLINK with its default half-period.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= LED_BLINK;
            half_q <= RST_HALF;
            cnt_q  <= '0;
            led_q  <= c_LED_INV;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            half_q <= half_d;
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            tick_q <= tick_d;
        end
    end

    // Next-state: a write restarts the channel, otherwise the mode drives the counter.
    always_comb begin
        mode_d = mode_q;
        half_d = half_q;
        cnt_d  = cnt_q;
        led_d  = led_q;
        tick_d = 1'b0;

        if (wr_i) begin
            mode_d = led_mode_e'(mode_i);
            half_d = half_i;
            cnt_d  = '0;
            led_d  = ((mode_i == c_MODE_ON) || (mode_i == c_MODE_ONESHOT)) ^ c_LED_INV;
        end else begin
            case (mode_q)
                LED_BLINK: begin
                    if (w_term) begin
                        cnt_d  = '0;
                        led_d  = ~led_q;
                        tick_d = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
                LED_ONESHOT: begin
                    if (w_term) begin
                        cnt_d  = '0;
                        led_d  = c_LED_INV;
                        tick_d = 1'b1;
                        mode_d = LED_OFF;
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    // OFF and ON hold their level with the counter parked.
                    cnt_d = '0;
                end
            endcase
        end
    end

    assign led_o  = led_q;
    assign tick_o = tick_q;

endmodule : led_blink_chan
`default_nettype wire

// File: rtl/led_blink_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_blink_ctrl
//  Description : Multi-channel LED blink controller. Decodes the write-strobe
//                configuration port into per-channel enables and instantiates
//                one led_blink_chan per channel.
//                Optional macro LED_BLINK_ACTIVE_LOW_EN inverts led_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_blink_ctrl
    import led_blink_pkg::*;
#(
    parameter int          NUM_CH       = 2,
    parameter int          CNT_W        = 24,
    parameter int unsigned DEFAULT_HALF = 5_000_000
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            cfg_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  cfg_ch,
    input  logic [1:0]                                      cfg_mode,
    input  logic [CNT_W-1:0]                                cfg_half,
    output logic [NUM_CH-1:0]                               led_out,
    output logic [NUM_CH-1:0]                               tick
);

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            // Channel k defaults to DEFAULT_HALF << k, truncated to the counter width.
            localparam logic [c_MAX_CNT_W-1:0] c_FULL_HALF = c_MAX_CNT_W'(DEFAULT_HALF) << k;
            localparam logic [CNT_W-1:0]       c_RST_HALF  = c_FULL_HALF[CNT_W-1:0];

            logic w_wr;

            // Out-of-range channel indices match no instance and are dropped.
            assign w_wr = cfg_we && (32'(cfg_ch) == k);

            led_blink_chan #(
                .CNT_W    (CNT_W),
                .RST_HALF (c_RST_HALF)
            ) u_chan (
                .clk    (clk),
                .rst    (rst),
                .wr_i   (w_wr),
                .mode_i (cfg_mode),
                .half_i (cfg_half),
                .led_o  (led_out[k]),
                .tick_o (tick[k])
            );
        end
    endgenerate

endmodule : led_blink_ctrl
`default_nettype wire

// File: tb/tb_led_blink_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_blink_ctrl
//  Description : Scoreboard bench for led_blink_ctrl. Expected LED/tick values
//                come from a time-since-restart model of each channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_blink_ctrl;

    localparam int NUM_CH       = 3;
    localparam int CNT_W        = 8;
    localparam int DEFAULT_HALF = 4;
    localparam int CH_W         = 2;

`ifdef LED_BLINK_ACTIVE_LOW_EN
    localparam logic [NUM_CH-1:0] INV = '1;
`else
    localparam logic [NUM_CH-1:0] INV = '0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [1:0]        cfg_mode;
    logic [CNT_W-1:0]  cfg_half;
    logic [NUM_CH-1:0] led_out;
    logic [NUM_CH-1:0] tick;

    always #5 clk = ~clk;

    led_blink_ctrl #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DEFAULT_HALF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_half (cfg_half),
        .led_out  (led_out),
        .tick     (tick)
    );

    typedef struct {
        logic [NUM_CH-1:0] led;
        logic [NUM_CH-1:0] tick;
    } exp_t;

    exp_t exp_q[$];

    // Model state: mode, effective half-period and cycles since last restart.
    int     m_mode [NUM_CH];
    longint m_heff [NUM_CH];
    longint m_t    [NUM_CH];

    int errors = 0;
    int checks = 0;

    // Advance the model by one clock edge with the inputs just applied.
    task automatic model_edge(input logic r, input logic we, input int ch,
                              input int mode, input int half);
        exp_t   e;
        longint hv;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r) begin
                hv        = (longint'(DEFAULT_HALF) << k) % 256;
                m_mode[k] = 2;
                m_heff[k] = (hv == 0) ? 1 : hv;
                m_t[k]    = 0;
            end else if (we && ch == k) begin
                m_mode[k] = mode;
                m_heff[k] = (half == 0) ? 1 : longint'(half);
                m_t[k]    = 0;
            end else begin
                m_t[k]    = m_t[k] + 1;
            end
            case (m_mode[k])
                0: begin e.led[k] = 1'b0; e.tick[k] = 1'b0; end
                1: begin e.led[k] = 1'b1; e.tick[k] = 1'b0; end
                2: begin
                    e.led[k]  = ((m_t[k] / m_heff[k]) % 2) == 1;
                    e.tick[k] = (m_t[k] > 0) && ((m_t[k] % m_heff[k]) == 0);
                end
                default: begin
                    e.led[k]  = m_t[k] < m_heff[k];
                    e.tick[k] = m_t[k] == m_heff[k];
                end
            endcase
        end
        e.led = e.led ^ INV;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, clock it, and record the expectation.
    task automatic step(input logic r, input logic we, input int ch,
                        input int mode, input int half);
        rst      = r;
        cfg_we   = we;
        cfg_ch   = CH_W'(ch);
        cfg_mode = 2'(mode);
        cfg_half = CNT_W'(half);
        @(posedge clk);
        model_edge(r, we, ch, mode, half);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents led_out/tick, compare against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (led_out !== e.led) begin
                errors++;
                $display("FAIL led_out @%0t: got %b expected %b", $time, led_out, e.led);
            end
            checks++;
            if (tick !== e.tick) begin
                errors++;
                $display("FAIL tick @%0t: got %b expected %b", $time, tick, e.tick);
            end
        end
    end

    initial begin
        int sel;
        int hf;
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_half = '0;

        // Reset, then free-running default blink on all channels.
        repeat (3) step(1'b1, 1'b0, 0, 0, 0);
        idle(40);
        // Reset and write together: reset wins.
        step(1'b1, 1'b1, 0, 1, 7);
        idle(10);
        // Reprogram ch0 mid-count to BLINK half=3.
        step(1'b0, 1'b1, 0, 2, 3);
        idle(20);
        // ONESHOT on ch1, half=5, then long quiet period.
        step(1'b0, 1'b1, 1, 3, 5);
        idle(60);
        // half=0 in BLINK toggles every cycle.
        step(1'b0, 1'b1, 2, 2, 0);
        idle(10);
        // Out-of-range channel index is ignored.
        step(1'b0, 1'b1, 3, 1, 9);
        idle(10);
        // OFF then ON on ch0.
        step(1'b0, 1'b1, 0, 0, 3);
        idle(20);
        step(1'b0, 1'b1, 0, 1, 3);
        idle(100);
        // Reset in the middle of a ONESHOT.
        step(1'b0, 1'b1, 1, 3, 20);
        idle(5);
        step(1'b1, 1'b0, 0, 0, 0);
        idle(30);
        // Same-mode rewrite still restarts the channel.
        step(1'b0, 1'b1, 2, 2, 6);
        idle(4);
        step(1'b0, 1'b1, 2, 2, 6);
        idle(15);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       hf = 0;
                1:       hf = $urandom_range(1, 4);
                2:       hf = $urandom_range(1, 12);
                default: hf = $urandom_range(0, 255);
            endcase
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
                 $urandom_range(0, 3), $urandom_range(0, 3), hf);
        end

        rst = 1'b0;
        cfg_we = 1'b0;
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_led_blink_ctrl
`default_nettype wire

// File: doc/led_blink_ctrl.md
Name: led_blink_ctrl

Overview:
- Parametrised, multi-channel successor to the fixed two-output clock divider that drives board LEDs.
- Each channel has a runtime-programmable half-period and one of four modes: OFF, ON, BLINK, ONESHOT.
- Each channel produces a registered LED output and a one-cycle tick on every LED transition caused by its counter.
- Sits between the system clock and the board LED pins; configured by a simple write-strobe interface from a controller or bench.

Parameters:
- NUM_CH, 2, number of independent LED channels (1..16).
- CNT_W, 24, width of the half-period and counter registers.
- DEFAULT_HALF, 5_000_000, reset half-period of channel 0. Channel k resets to DEFAULT_HALF << k, truncated to CNT_W bits.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  configuration write strobe, one cycle.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel index.
- cfg_mode  in  2  mode: 00 OFF, 01 ON, 10 BLINK, 11 ONESHOT.
- cfg_half  in  CNT_W  half-period in clk cycles.
- led_out  out  NUM_CH  registered LED drive, one bit per channel.
- tick  out  NUM_CH  one-cycle pulse per channel on each counter-caused LED transition.

Behaviour:
- Reset (rst=1 at a clock edge), every channel:
  - mode=BLINK, half=DEFAULT_HALF<<k, counter=0.
  - led_out=0, tick=0.
  - rst takes priority over cfg_we in the same cycle.
  - Reset mid-count or mid-ONESHOT aborts the operation and restarts BLINK from the reset state.
- Effective half-period heff = (half==0) ? 1 : half.
- Configuration write (cfg_we=1 and cfg_ch<NUM_CH, at edge n), applied to that channel only:
  - Latch mode and half; counter cleared to 0; tick forced 0 for that cycle.
  - led_out after edge n: OFF→0, ON→1, BLINK→0, ONESHOT→1.
  - A write restarts the channel even if mode and half are unchanged.
  - Writes with cfg_ch ≥ NUM_CH are ignored.
- OFF / ON: counter held at 0; led constant; tick never asserts.
- BLINK:
  - While counter < heff−1: counter increments each cycle.
  - When counter == heff−1: led toggles, tick=1 for that cycle, counter returns to 0.
  - Output period is 2·heff cycles at 50% duty; first rising edge occurs heff cycles after reset or write.
- ONESHOT:
  - led stays 1 for exactly heff cycles, counting from the first high cycle.
  - On the terminal count: led→0, tick=1, mode becomes OFF autonomously.
  - The channel stays OFF until the next write.
- Counter width rule: counter never exceeds heff−1 and never wraps past 2^CNT_W−1.
- tick is registered and coincident with the led_out edge it reports.
- Channels are fully independent; simultaneous terminal counts on several channels all take effect in the same cycle.

Optional Feature:
- Macro: LED_BLINK_ACTIVE_LOW_EN.
- Defined: led_out is driven inverted for active-low boards.
  - Reset value is all ones.
  - OFF drives 1, ON drives 0; BLINK starts at 1; ONESHOT drives 0 for the pulse.
  - tick is unchanged.
- Undefined: active-high as described in Behaviour.
- Inversion is applied at the output register, so latency is unchanged.

Decomposition:
- Package led_blink_pkg contains:
  - typedef enum logic [1:0] led_mode_e {LED_OFF, LED_ON, LED_BLINK, LED_ONESHOT};
  - mode encoding constants;
  - a function returning heff from half.
- Sub-module led_blink_chan implements one channel: mode register, half register, counter, led and tick flops. It is parametrised by CNT_W and its reset half-period.
- The top level generates NUM_CH instances and decodes cfg_we/cfg_ch into per-channel write enables.

Test Plan:
- Reset check (NUM_CH=2, CNT_W=8, DEFAULT_HALF=4): release rst → ch0 led rises 4 cycles later with period 8; ch1 rises 8 cycles later with period 16; tick pulses at every edge.
- BLINK reprogram: write ch0 mode=10, half=3 mid-count → led_out[0]=0 next cycle; toggles every 3 cycles thereafter; ch1 undisturbed.
- ONESHOT: write ch1 mode=11, half=5 → led_out[1]=1 for exactly 5 cycles, then 0 with one tick; remains 0 for ≥50 cycles.
- Boundaries:
  - half=0 in BLINK → toggles every cycle with tick every cycle.
  - cfg_ch=2 with NUM_CH=2 → no channel changes.
  - rst and cfg_we asserted together → reset state wins.
- OFF/ON: write mode=00 then mode=01 → led_out constant 0 then 1; tick stays 0 for 100 cycles.
- LED_BLINK_ACTIVE_LOW_EN defined: repeat the reset check → led_out resets to 2'b11 and every observed level is inverted; tick timing identical.
